// File: rtl/bolme_birimi.sv
`default_nettype none
// ============================================================================
// Module   : bolme_birimi
// Brief    : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU in YURUT.
// Revision : 1.0 - initial release
// ============================================================================
module bolme_birimi #(
    parameter int VERI_BIT = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                istek_i,
    input  logic [1:0]          islem_i,
    input  logic [VERI_BIT-1:0] bolunen_i,
    input  logic [VERI_BIT-1:0] bolen_i,
    input  logic                durdur_i,
    input  logic                iptal_i,
    output logic [VERI_BIT-1:0] sonuc_o,
    output logic                sonuc_gecerli_o,
    output logic                hazir_o
);

    localparam int                  c_SAYAC_W  = $clog2(VERI_BIT);
    localparam logic [c_SAYAC_W-1:0] c_SON     = c_SAYAC_W'(VERI_BIT - 1);
    localparam logic [c_SAYAC_W-1:0] c_SAYAC_1 = c_SAYAC_W'(1);
    localparam logic [VERI_BIT-1:0] c_EN_KUCUK = {1'b1, {(VERI_BIT-1){1'b0}}};

    localparam logic [1:0] c_BOSTA   = 2'd0;
    localparam logic [1:0] c_HESAPLA = 2'd1;
    localparam logic [1:0] c_BITTI   = 2'd2;

    logic [1:0]          r_durum;
    logic [c_SAYAC_W-1:0] r_sayac;
    logic                r_kalan_sec;
    logic                r_bolum_isaret;
    logic                r_kalan_isaret;
    logic [VERI_BIT-1:0] r_bolen;
    logic [VERI_BIT-1:0] r_bolum;
    logic [VERI_BIT-1:0] r_kalan;
    logic [VERI_BIT-1:0] r_sonuc;
    logic                r_gecerli;

    logic                w_isaretli;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [VERI_BIT-1:0] w_a_mag;
    logic [VERI_BIT-1:0] w_b_mag;
    logic                w_sifira;
    logic                w_tasma;
    logic [VERI_BIT:0]   w_kaydir;
    logic [VERI_BIT:0]   w_fark;
    logic [VERI_BIT-1:0] w_yeni_kalan;
    logic [VERI_BIT-1:0] w_yeni_bolum;
    logic [VERI_BIT-1:0] w_son_bolum;
    logic [VERI_BIT-1:0] w_son_kalan;

    assign w_isaretli = ~islem_i[0];
    assign w_a_neg    = w_isaretli & bolunen_i[VERI_BIT-1];
    assign w_b_neg    = w_isaretli & bolen_i[VERI_BIT-1];
    assign w_a_mag    = w_a_neg ? -bolunen_i : bolunen_i;
    assign w_b_mag    = w_b_neg ? -bolen_i : bolen_i;
    assign w_sifira   = (bolen_i == '0);
    assign w_tasma    = w_isaretli & (bolunen_i == c_EN_KUCUK) & (bolen_i == '1);

    // Partial remainder stays below |b|, so the shifted value fits in VERI_BIT+1 bits.
    assign w_kaydir     = {r_kalan, r_bolum[VERI_BIT-1]};
    assign w_fark       = w_kaydir - {1'b0, r_bolen};
    assign w_yeni_kalan = w_fark[VERI_BIT] ? w_kaydir[VERI_BIT-1:0] : w_fark[VERI_BIT-1:0];
    assign w_yeni_bolum = {r_bolum[VERI_BIT-2:0], ~w_fark[VERI_BIT]};
    assign w_son_bolum  = r_bolum_isaret ? -w_yeni_bolum : w_yeni_bolum;
    assign w_son_kalan  = r_kalan_isaret ? -w_yeni_kalan : w_yeni_kalan;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum        <= c_BOSTA;
            r_sayac        <= '0;
            r_kalan_sec    <= 1'b0;
            r_bolum_isaret <= 1'b0;
            r_kalan_isaret <= 1'b0;
            r_bolen        <= '0;
            r_bolum        <= '0;
            r_kalan        <= '0;
            r_sonuc        <= '0;
            r_gecerli      <= 1'b0;
        end else if (iptal_i) begin
            r_durum   <= c_BOSTA;
            r_gecerli <= 1'b0;
        end else begin
            case (r_durum)
                c_BOSTA: begin
                    if (istek_i) begin
                        r_kalan_sec    <= islem_i[1];
                        r_bolum_isaret <= w_a_neg ^ w_b_neg;
                        r_kalan_isaret <= w_a_neg;
                        r_bolen        <= w_b_mag;
                        r_bolum        <= w_a_mag;
                        r_kalan        <= '0;
                        r_sayac        <= '0;
                        if (w_sifira) begin
                            r_sonuc   <= islem_i[1] ? bolunen_i : '1;
                            r_gecerli <= 1'b1;
                            r_durum   <= c_BITTI;
                        end else if (w_tasma) begin
                            r_sonuc   <= islem_i[1] ? '0 : c_EN_KUCUK;
                            r_gecerli <= 1'b1;
                            r_durum   <= c_BITTI;
                        end else begin
                            r_durum <= c_HESAPLA;
                        end
                    end
                end
                c_HESAPLA: begin
                    r_kalan <= w_yeni_kalan;
                    r_bolum <= w_yeni_bolum;
                    r_sayac <= r_sayac + c_SAYAC_1;
                    if (r_sayac == c_SON) begin
                        r_sonuc   <= r_kalan_sec ? w_son_kalan : w_son_bolum;
                        r_gecerli <= 1'b1;
                        r_durum   <= c_BITTI;
                    end
                end
                c_BITTI: begin
                    if (!durdur_i) begin
                        r_gecerli <= 1'b0;
                        r_durum   <= c_BOSTA;
                    end
                end
                default: begin
                    r_gecerli <= 1'b0;
                    r_durum   <= c_BOSTA;
                end
            endcase
        end
    end

    assign sonuc_o         = r_sonuc;
    assign sonuc_gecerli_o = r_gecerli;
    assign hazir_o         = ~(istek_i && (r_durum != c_BITTI));

endmodule
`default_nettype wire
